audio_gain_fifo: RTL and testbench
==================================

// Module: audio_gain_fifo
// PURPOSE
//  Stereo sample stage between the I2S controller's receive outputs (D_L_O/D_R_O) and its transmit inputs (D_L_I/D_R_I).
//  Applies a programmable digital gain with saturation to each captured frame.
//  Buffers processed frames in a small FIFO; the transmit side pops one frame per I2S frame request.
//  Decouples capture and playback timing; reports overflow and underflow.
// PARAMETERS
//  DW     24  sample width, signed two's complement
//  DEPTH  8   FIFO depth in stereo frames; power of 2, >= 2
//  GW     8   gain width, unsigned Q2.6 (0x40 = unity)
// PORTS
//  clk        in   1             system clock
//  rst_n      in   1             asynchronous active-low reset
//  in_l       in   DW            left sample from I2S receive path
//  in_r       in   DW            right sample from I2S receive path
//  in_valid   in   1             1-cycle strobe: in_l/in_r hold a new frame
//  gain       in   GW            gain, Q2.6; sampled on the in_valid cycle
//  tx_req     in   1             1-cycle strobe: I2S transmitter needs the next frame
//  out_l      out  DW            left sample to I2S transmit path (registered, held)
//  out_r      out  DW            right sample to I2S transmit path (registered, held)
//  fill       out  clog2(DEPTH)+1  frames currently stored
//  ovf        out  1             sticky: a frame was dropped because the FIFO was full
//  unf        out  1             sticky: tx_req arrived while the FIFO was empty
//  clr_flags  in   1             synchronous clear of ovf, unf and peak registers
//  peak_l     out  DW-1          left post-gain peak magnitude (PEAK_METER_EN only)
//  peak_r     out  DW-1          right post-gain peak magnitude (PEAK_METER_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, fill=0, out_l=out_r=0, ovf=unf=0, peaks=0, pipeline valids cleared.
//    Reset mid-frame discards all in-flight and stored frames.
//  Stage 1 (cycle N+1 after in_valid at N): p = signed(in) * {1'b0, gain}; full-width product, DW+GW+1 bits.
//  Stage 2 (N+2): q = p >>> 6 (arithmetic shift, truncation toward -inf).
//    Saturate q to [-2^(DW-1), 2^(DW-1)-1]; write {l,r} to the FIFO.
//    The frame is poppable from cycle N+3.
//  gain=0 gives 0; 0x40 gives bit-exact passthrough; 0xFF gives x3.984 with saturation.
//  Write: if the FIFO is full at stage 2 and no pop occurs in that cycle:
//    drop the frame and set ovf; stored data is unchanged.
//  Pop: tx_req at cycle M with fill>0 loads out_l/out_r from the head at M+1 and decrements fill.
//  Underflow: tx_req with fill=0 sets unf; out_l/out_r are forced to 0 at M+1 (silence, not a repeat).
//  Simultaneous write and pop:
//    - when full: the pop frees the slot, the write is accepted, fill is unchanged, ovf is not set.
//    - when empty: no bypass; the pop underflows (unf=1, out=0) and the write is stored (fill=1).
//  Pointers wrap modulo DEPTH; fill ranges 0..DEPTH.
//  back-to-back in_valid on consecutive cycles is supported (fully pipelined, 1 frame/cycle).
//  clr_flags: ovf/unf/peaks are 0 next cycle. If a set event occurs in the same cycle, set wins.
//  out_l/out_r hold their value between pops.
// CONFIGURATION
//  PEAK_METER_EN defined:
//    - peak_x tracks the max |post-gain sample|, updated at stage 2 whether or not the frame was dropped.
//    - |-2^(DW-1)| is clamped to 2^(DW-1)-1.
//  PEAK_METER_EN undefined: peak_l/peak_r are driven constant 0 and no peak logic is built.
// TESTING
//  T1 unity: gain=0x40, in_l=0x123456, in_r=0xFEDCBA, then tx_req 3 cycles later
//    -> out_l=0x123456, out_r=0xFEDCBA; fill 1->0.
//  T2 saturation: gain=0xFF, in_l=0x400000, in_r=0xC00000
//    -> out_l=0x7FFFFF, out_r=0x800000; with PEAK_METER_EN, peak_l=peak_r=0x7FFFFF.
//  T3 attenuation/rounding: gain=0x20, in_l=-3 (0xFFFFFD)
//    -> out_l=0xFFFFFE (-2, floor of -1.5).
//  T4 overflow: DEPTH=8, 9 frames pushed, no tx_req
//    -> fill=8, ovf=1; the 8 pops return frames 1..8; the 9th frame is absent.
//  T5 underflow plus edge cases:
//    - tx_req on an empty FIFO -> unf=1, out=0.
//    - push and pop in the same cycle while full -> fill stays 8, ovf stays 0.
//    - clr_flags -> ovf=unf=0.
//  T6 reset mid-stream: assert rst_n=0 with fill=5 and a frame in stage 1
//    -> immediately fill=0, out=0, flags=0; after release the first tx_req underflows.

Source files
------------

// File: rtl/audio_gain_fifo.sv
// Stereo gain stage with saturation feeding a small frame FIFO for I2S playback.
// Optional peak meter built only when PEAK_METER_EN is defined.
module audio_gain_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 8,
  parameter int GW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              in_l,
  input  logic [DW-1:0]              in_r,
  input  logic                       in_valid,
  input  logic [GW-1:0]              gain,
  input  logic                       tx_req,
  output logic [DW-1:0]              out_l,
  output logic [DW-1:0]              out_r,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       ovf,
  output logic                       unf,
  input  logic                       clr_flags,
  output logic [DW-2:0]              peak_l,
  output logic [DW-2:0]              peak_r
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + GW + 1;

  function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] q);
    if (&q[PW-1:DW-1] || ~|q[PW-1:DW-1]) return q[DW-1:0];
    else if (q[PW-1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic signed [PW-1:0] w_p_l, w_p_r, w_q_l, w_q_r;
  logic signed [PW-1:0] r_p_l, r_p_r;
  logic                 r_v1, r_v2;
  logic [DW-1:0]        r_s_l, r_s_r;

  assign w_p_l = PW'($signed(in_l)) * PW'($signed({1'b0, gain}));
  assign w_p_r = PW'($signed(in_r)) * PW'($signed({1'b0, gain}));
  assign w_q_l = r_p_l >>> 6;
  assign w_q_r = r_p_r >>> 6;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_p_l <= '0;
      r_p_r <= '0;
      r_s_l <= '0;
      r_s_r <= '0;
    end else begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      if (in_valid) begin
        r_p_l <= w_p_l;
        r_p_r <= w_p_r;
      end
      if (r_v1) begin
        r_s_l <= sat(w_q_l);
        r_s_r <= sat(w_q_r);
      end
    end
  end

  logic [2*DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_fill;
  logic            w_full, w_empty, w_pop, w_wr;

  assign w_full  = (r_fill == (AW+1)'(DEPTH));
  assign w_empty = (r_fill == '0);
  assign w_pop   = tx_req && !w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts
  assign w_wr    = r_v2 && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= {r_s_l, r_s_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
      out_l  <= '0;
      out_r  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      if (w_pop) begin
        {out_l, out_r} <= r_mem[r_rp];
      end else if (tx_req) begin
        out_l <= '0;
        out_r <= '0;
      end
      if (clr_flags) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (r_v2 && w_full && !w_pop) ovf <= 1'b1;
      if (tx_req && w_empty) unf <= 1'b1;
    end
  end

  assign fill = r_fill;

`ifdef PEAK_METER_EN
  function automatic logic [DW-2:0] mag(input logic [DW-1:0] x);
    logic [DW-1:0] n;
    n = -x;
    if (!x[DW-1]) return x[DW-2:0];
    else if (n[DW-1]) return '1;
    else return n[DW-2:0];
  endfunction

  logic [DW-2:0] r_pk_l, r_pk_r, w_base_l, w_base_r, w_m_l, w_m_r;

  assign w_base_l = clr_flags ? '0 : r_pk_l;
  assign w_base_r = clr_flags ? '0 : r_pk_r;
  assign w_m_l    = mag(r_s_l);
  assign w_m_r    = mag(r_s_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pk_l <= '0;
      r_pk_r <= '0;
    end else begin
      r_pk_l <= (r_v2 && w_m_l > w_base_l) ? w_m_l : w_base_l;
      r_pk_r <= (r_v2 && w_m_r > w_base_r) ? w_m_r : w_base_r;
    end
  end

  assign peak_l = r_pk_l;
  assign peak_r = r_pk_r;
`else
  assign peak_l = '0;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_audio_gain_fifo.sv
// Directed bench for audio_gain_fifo: pops are checked by a scoreboard monitor,
// status outputs are checked inline by the stimulus.
module tb_audio_gain_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_l = '0, in_r = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  gain = '0;
  logic        tx_req = 1'b0;
  logic        clr_flags = 1'b0;
  logic [23:0] out_l, out_r;
  logic [3:0]  fill;
  logic        ovf, unf;
  logic [22:0] peak_l, peak_r;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q [$];

  audio_gain_fifo #(.DW(24), .DEPTH(8), .GW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .gain(gain),
    .tx_req(tx_req), .out_l(out_l), .out_r(out_r), .fill(fill),
    .ovf(ovf), .unf(unf), .clr_flags(clr_flags),
    .peak_l(peak_l), .peak_r(peak_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r,
                      input logic [7:0] g);
    in_l = l; in_r = r; gain = g; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop(input logic [23:0] el, input logic [23:0] er);
    exp_q.push_back({el, er});
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  // Monitor: a tx_req sampled at an edge yields new outputs after that edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && tx_req) begin
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h_%0h expected none",
                   out_l, out_r);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          if ({out_l, out_r} !== e) begin
            errors++;
            $display("FAIL pop_data: got 0x%0h_%0h expected 0x%0h_%0h",
                     out_l, out_r, e[47:24], e[23:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    #2;
    tick();
    chk("rst_fill", 32'(fill), 0);
    chk("rst_out", {8'h0, out_l}, 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    rst_n = 1'b1;
    tick();

    // T1 unity passthrough
    push(24'h123456, 24'hFEDCBA, 8'h40);
    tick(); tick();
    chk("t1_fill1", 32'(fill), 1);
    pop(24'h123456, 24'hFEDCBA);
    chk("t1_fill0", 32'(fill), 0);

    // T2 saturation both directions
    push(24'h400000, 24'hC00000, 8'hFF);
    tick(); tick();
    pop(24'h7FFFFF, 24'h800000);
`ifdef PEAK_METER_EN
    chk("t2_peak_l", 32'(peak_l), 32'h7FFFFF);
    chk("t2_peak_r", 32'(peak_r), 32'h7FFFFF);
`endif

    // T3 attenuation floors toward -inf; gain 0 gives silence
    push(24'hFFFFFD, 24'h000005, 8'h20);
    push(24'h123456, 24'h7FFFFF, 8'h00);
    tick(); tick();
    chk("t3_fill2", 32'(fill), 2);
    pop(24'hFFFFFE, 24'h000002);
    pop(24'h000000, 24'h000000);

    // T4 overflow: nine back-to-back frames, the ninth is dropped
    for (int k = 1; k <= 9; k++) push(24'(k), 24'(-k), 8'h40);
    tick(); tick();
    chk("t4_fill8", 32'(fill), 8);
    chk("t4_ovf", 32'(ovf), 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t4_clr_ovf", 32'(ovf), 0);

    // Write and pop in the same cycle while full
    push(24'h00000A, 24'hFFFFF6, 8'h40);
    tick();
    pop(24'd1, 24'hFFFFFF);
    chk("t5_full_fill", 32'(fill), 8);
    chk("t5_full_ovf", 32'(ovf), 0);
    for (int k = 2; k <= 8; k++) pop(24'(k), 24'(-k));
    pop(24'h00000A, 24'hFFFFF6);
    chk("t4_drain", 32'(fill), 0);

    // T5 underflow gives silence and sets unf
    pop(24'h0, 24'h0);
    chk("t5_unf", 32'(unf), 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t5_clr_unf", 32'(unf), 0);

    // Underflow set in the same cycle as clear: set wins
    clr_flags = 1'b1;
    pop(24'h0, 24'h0);
    clr_flags = 1'b0;
    chk("t5_set_wins", 32'(unf), 1);

    // Write and pop together while empty: no bypass
    push(24'h000777, 24'h000888, 8'h40);
    tick();
    pop(24'h0, 24'h0);
    chk("t5_empty_fill", 32'(fill), 1);
    pop(24'h000777, 24'h000888);

    // T6 reset mid-stream
    for (int k = 1; k <= 6; k++) push(24'(16 + k), 24'(32 + k), 8'h40);
    tick(); tick();
    pop(24'd17, 24'd33);
    chk("t6_fill5", 32'(fill), 5);
    push(24'h0000AA, 24'h0000BB, 8'h40);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fill", 32'(fill), 0);
    chk("t6_rst_out", {8'h0, out_l} | {8'h0, out_r}, 0);
    chk("t6_rst_flags", {30'h0, ovf, unf}, 0);
`ifdef PEAK_METER_EN
    chk("t6_rst_peak", 32'(peak_l), 0);
`endif
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_post_fill", 32'(fill), 0);
    pop(24'h0, 24'h0);
    chk("t6_post_unf", 32'(unf), 1);

    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
